// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake with a 2-entry skid buffer.
// Optional stall/bubble performance counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  FLUSH,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    output logic [CNT_WIDTH-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [CTRL_WIDTH-1:0] r_main_ctrl;
    logic [DATA_WIDTH-1:0] r_main_data;
    logic [CTRL_WIDTH-1:0] r_skid_ctrl;
    logic [DATA_WIDTH-1:0] r_skid_data;

    logic w_accept;
    logic w_consume;

    assign w_accept  = in_valid && r_in_ready;
    assign w_consume = r_out_valid && out_ready;

    // Outputs come straight from the main register; main ctrl is zeroed whenever the stage empties.
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_ctrl  = r_main_ctrl;
    assign out_data  = r_main_data;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (FLUSH) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main_ctrl <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_main_ctrl <= in_ctrl;
                        r_main_data <= in_data;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_consume) begin
                        r_main_ctrl <= in_ctrl;
                        r_main_data <= in_data;
                    end else if (w_accept) begin
                        r_skid_ctrl <= in_ctrl;
                        r_skid_data <= in_data;
                        r_in_ready  <= 1'b0;
                        r_state     <= ST_TWO;
                    end else if (w_consume) begin
                        r_main_ctrl <= '0;
                        r_out_valid <= 1'b0;
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_consume) begin
                        r_main_ctrl <= r_skid_ctrl;
                        r_main_data <= r_skid_data;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_ONE;
                    end
                end
                default: begin
                    r_main_ctrl <= '0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_state     <= ST_EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_bubble_cnt;

    // Saturating counters; FLUSH deliberately leaves them alone.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (r_out_valid && !out_ready && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (!r_out_valid && (r_bubble_cnt != CNT_MAX)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg against a queue-based model of a 2-deep FIFO stage.
// Counter expectations follow PIPE_STAGE_PERF_EN: model counts when defined, zero otherwise.
module tb_pipe_stage_reg;

    localparam int DW = 32;
    localparam int CW = 16;
    localparam int NW = 4;
    localparam int CMAX = (1 << NW) - 1;
`ifdef PIPE_STAGE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          CLK;
    logic          CLR;
    logic          FLUSH;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [NW-1:0] stall_cnt;
    logic [NW-1:0] bubble_cnt;

    pipe_stage_reg #(
        .DATA_WIDTH(DW),
        .CTRL_WIDTH(CW),
        .CNT_WIDTH (NW)
    ) dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .FLUSH     (FLUSH),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    beat_t         q[$];
    logic [DW-1:0] m_last;
    int            m_stall;
    int            m_bubble;
    int            n_run;
    int            n_fail;

    // One clock of stimulus; the model advances with the FIFO rules using pre-edge occupancy.
    task automatic drive(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                         input logic ordy, input logic fl, input logic clr);
        bit    acc;
        bit    con;
        beat_t b;
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = id;
        out_ready = ordy;
        FLUSH     = fl;
        CLR       = clr;
        acc = iv && (q.size() < 2);
        con = (q.size() > 0) && ordy;
        if (clr) begin
            m_stall  = 0;
            m_bubble = 0;
        end else begin
            if ((q.size() > 0) && !ordy && (m_stall < CMAX)) m_stall++;
            if ((q.size() == 0) && (m_bubble < CMAX)) m_bubble++;
        end
        @(posedge CLK);
        if (clr) begin
            q.delete();
            m_last = '0;
        end else if (fl) begin
            q.delete();
        end else begin
            if (con) void'(q.pop_front());
            if (acc) begin
                b.c = ic;
                b.d = id;
                q.push_back(b);
            end
        end
        if (q.size() > 0) m_last = q[0].d;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        n_run += 6;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0h want 0", out_valid); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0h want 1", in_ready); end
        if (out_ctrl !== '0) begin n_fail++; $display("FAIL reset_out_ctrl got %0h want 0", out_ctrl); end
        if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %0h want 0", out_data); end
        if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall_cnt got %0h want 0", stall_cnt); end
        if (bubble_cnt !== '0) begin n_fail++; $display("FAIL reset_bubble_cnt got %0h want 0", bubble_cnt); end
    endtask

    task automatic test_stream();
        logic [31:0]   r;
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        for (int k = 0; k < 8; k++) begin
            r = $urandom;
            c = r[CW-1:0] | 16'h0001;
            d = $urandom;
            drive(1'b1, c, d, 1'b1, 1'b0, 1'b0);
            n_run += 4;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %0h want 1", k, out_valid); end
            if (out_ctrl !== c) begin n_fail++; $display("FAIL stream_ctrl[%0d] got %0h want %0h", k, out_ctrl, c); end
            if (out_data !== d) begin n_fail++; $display("FAIL stream_data[%0d] got %0h want %0h", k, out_data, d); end
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d] got %0h want 1", k, in_ready); end
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        n_run += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain_valid got %0h want 0", out_valid); end
        if (out_ctrl !== '0) begin n_fail++; $display("FAIL stream_drain_ctrl got %0h want 0", out_ctrl); end
        if (out_data !== m_last) begin n_fail++; $display("FAIL stream_drain_hold got %0h want %0h", out_data, m_last); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] c;
        a = $urandom;
        b = $urandom;
        c = $urandom;
        drive(1'b1, 16'h00a1, a, 1'b0, 1'b0, 1'b0);
        n_run += 2;
        if (out_data !== a) begin n_fail++; $display("FAIL bp_a_main got %0h want %0h", out_data, a); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_one_ready got %0h want 1", in_ready); end
        drive(1'b1, 16'h00b2, b, 1'b0, 1'b0, 1'b0);
        n_run += 2;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_two_ready got %0h want 0", in_ready); end
        if (out_data !== a) begin n_fail++; $display("FAIL bp_two_main got %0h want %0h", out_data, a); end
        drive(1'b1, 16'h00c3, c, 1'b0, 1'b0, 1'b0);
        n_run += 2;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_c_held_ready got %0h want 0", in_ready); end
        if (out_ctrl !== 16'h00a1) begin n_fail++; $display("FAIL bp_c_held_ctrl got %0h want a1", out_ctrl); end
        drive(1'b1, 16'h00c3, c, 1'b1, 1'b0, 1'b0);
        n_run += 3;
        if (out_data !== b) begin n_fail++; $display("FAIL bp_order_b got %0h want %0h", out_data, b); end
        if (out_ctrl !== 16'h00b2) begin n_fail++; $display("FAIL bp_order_b_ctrl got %0h want b2", out_ctrl); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %0h want 1", in_ready); end
        drive(1'b1, 16'h00c3, c, 1'b1, 1'b0, 1'b0);
        n_run += 1;
        if (out_data !== c) begin n_fail++; $display("FAIL bp_order_c got %0h want %0h", out_data, c); end
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        n_run += 1;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got %0h want 0", out_valid); end
    endtask

    task automatic test_flush();
        logic [DW-1:0] a;
        logic [DW-1:0] e;
        a = $urandom;
        e = $urandom;
        drive(1'b1, 16'h0011, a, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h0022, ~a, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h0033, 32'hdead_beef, 1'b0, 1'b1, 1'b0);
        n_run += 4;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_two_valid got %0h want 0", out_valid); end
        if (out_ctrl !== '0) begin n_fail++; $display("FAIL flush_two_ctrl got %0h want 0", out_ctrl); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_two_ready got %0h want 1", in_ready); end
        if (out_data !== a) begin n_fail++; $display("FAIL flush_two_hold got %0h want %0h", out_data, a); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
            n_run += 1;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ghost[%0d] got %0h want 0", i, out_valid); end
        end
        drive(1'b1, 16'h0044, e, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h0055, ~e, 1'b1, 1'b1, 1'b0);
        n_run += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_one_valid got %0h want 0", out_valid); end
        if (out_data !== e) begin n_fail++; $display("FAIL flush_one_hold got %0h want %0h", out_data, e); end
    endtask

    task automatic test_flush_clr();
        logic [DW-1:0] j;
        j = $urandom | 32'h1;
        drive(1'b1, 16'h0066, j, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h0077, ~j, 1'b0, 1'b1, 1'b1);
        n_run += 4;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fclr_valid got %0h want 0", out_valid); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fclr_ready got %0h want 1", in_ready); end
        if (out_ctrl !== '0) begin n_fail++; $display("FAIL fclr_ctrl got %0h want 0", out_ctrl); end
        if (out_data !== '0) begin n_fail++; $display("FAIL fclr_data got %0h want 0", out_data); end
        drive(1'b1, 16'h0088, j, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        n_run += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fempty_valid got %0h want 0", out_valid); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fempty_ready got %0h want 1", in_ready); end
        if (out_data !== j) begin n_fail++; $display("FAIL fempty_data got %0h want %0h", out_data, j); end
    endtask

    task automatic test_random();
        logic [31:0]   r;
        logic [CW-1:0] ec;
        int            es;
        int            eb;
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            drive(r[0] | r[1], r[31:16], $urandom, r[2] | r[3], (r[9:5] == 5'd0), (r[15:10] == 6'd0));
            ec = (q.size() > 0) ? q[0].c : '0;
            es = PERF ? m_stall : 0;
            eb = PERF ? m_bubble : 0;
            n_run += 6;
            if (out_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid[%0d] got %0h want %0h", i, out_valid, q.size() > 0); end
            if (in_ready !== (q.size() < 2)) begin n_fail++; $display("FAIL rnd_ready[%0d] got %0h want %0h", i, in_ready, q.size() < 2); end
            if (out_ctrl !== ec) begin n_fail++; $display("FAIL rnd_ctrl[%0d] got %0h want %0h", i, out_ctrl, ec); end
            if (out_data !== m_last) begin n_fail++; $display("FAIL rnd_data[%0d] got %0h want %0h", i, out_data, m_last); end
            if (int'(stall_cnt) !== es) begin n_fail++; $display("FAIL rnd_stall[%0d] got %0d want %0d", i, stall_cnt, es); end
            if (int'(bubble_cnt) !== eb) begin n_fail++; $display("FAIL rnd_bubble[%0d] got %0d want %0d", i, bubble_cnt, eb); end
        end
    endtask

    task automatic test_stall_sat();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 16'h0099, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        end
        n_run += 3;
        if (stall_cnt !== (PERF ? 4'd15 : 4'd0)) begin n_fail++; $display("FAIL stall_sat got %0d want %0d", stall_cnt, PERF ? 15 : 0); end
        if (bubble_cnt !== (PERF ? 4'd1 : 4'd0)) begin n_fail++; $display("FAIL stall_bubble got %0d want %0d", bubble_cnt, PERF ? 1 : 0); end
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid got %0h want 1", out_valid); end
    endtask

    initial begin
        n_run     = 0;
        n_fail    = 0;
        m_last    = '0;
        m_stall   = 0;
        m_bubble  = 0;
        CLR       = 1'b1;
        FLUSH     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_flush_clr();
        test_random();
        test_stall_sat();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
